// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the ALU arbiter.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_EQ  = 4'd4;
  localparam logic [3:0] OP_LT  = 4'd5;
  localparam logic [3:0] OP_GT  = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two issue front-ends and the ALU arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
);

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*WIDTH-1:0]   req_a;
  logic [2*WIDTH-1:0]   req_b;
  logic [7:0]           req_op;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [WIDTH-1:0]     rsp_o;
  logic                 rsp_of_und;
  logic                 rsp_err;
  logic                 rsp_zero;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Requester side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_o, rsp_of_und, rsp_err, rsp_zero, err_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_o, rsp_of_und, rsp_err, rsp_zero, err_cnt
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Every output is fully defined
// for every opcode so nothing undefined can be registered downstream.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] o_o,
  output logic             of_und_o,
  output logic             err_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   shl_wide;
  logic                 b_big;

  // Upper bit of the extended sum/difference is carry-out/borrow; the upper
  // half of the widened left shift holds whatever was shifted out.
  assign sum      = {1'b0, a_i} + {1'b0, b_i};
  assign diff     = {1'b0, a_i} - {1'b0, b_i};
  assign shl_wide = {{WIDTH{1'b0}}, a_i} << b_i;
  assign b_big    = (b_i >= WIDTH_V);

  // Opcode decode with all outputs defaulted to zero.
  always_comb begin
    o_o      = '0;
    of_und_o = 1'b0;
    err_o    = 1'b0;
    zero_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        o_o      = sum[WIDTH-1:0];
        of_und_o = sum[WIDTH];
      end
      OP_SUB: begin
        o_o      = diff[WIDTH-1:0];
        of_und_o = diff[WIDTH];
      end
      OP_SHL: begin
        if (b_big) begin
          of_und_o = |a_i;
        end else begin
          o_o      = shl_wide[WIDTH-1:0];
          of_und_o = |shl_wide[2*WIDTH-1:WIDTH];
        end
      end
      OP_SHR: begin
        if (!b_big) o_o = a_i >> b_i;
      end
      OP_EQ:   zero_o = (a_i == b_i);
      OP_LT:   zero_o = (a_i <  b_i);
      OP_GT:   zero_o = (a_i >  b_i);
      default: err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; result is
// registered and returned to the winner, ERR results are counted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_e               state_q, state_d;
  logic                 owner_q, last_grant_q;
  logic                 grant, accept;
  logic [1:0]           req_ready;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     rsp_o_q;
  logic                 rsp_of_und_q, rsp_err_q, rsp_zero_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [WIDTH-1:0]     alu_o;
  logic                 alu_of_und, alu_err, alu_zero;

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .o_o      (alu_o),
    .of_und_o (alu_of_und),
    .err_o    (alu_err),
    .zero_o   (alu_zero)
  );

  // Grant selection and next-state; on contention the requester that did not
  // win last time goes first.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    grant     = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_d          = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch on accept, result capture in EXEC, saturating error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_o_q      <= '0;
      rsp_of_und_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        a_q          <= grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        b_q          <= grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        op_q         <= grant ? bus.req_op[7:4] : bus.req_op[3:0];
      end
      if (state_q == EXEC) begin
        rsp_o_q      <= alu_o;
        rsp_of_und_q <= alu_of_und;
        rsp_err_q    <= alu_err;
        rsp_zero_q   <= alu_zero;
        if (alu_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_o      = rsp_o_q;
  assign bus.rsp_of_und = rsp_of_und_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for the ALU arbiter.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_cnt  = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(8), .ERR_CNT_W(8)) bus ();

  alu_arbiter #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int         r;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] o;
    logic       of_und;
    logic       err;
    logic       zero;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset rsp_o", 32'(bus.rsp_o), 0);
    chk("reset flags", 32'({bus.rsp_of_und, bus.rsp_err, bus.rsp_zero}), 0);
    chk("reset err_cnt", 32'(bus.err_cnt), 0);
    chk("reset req_ready", 32'(bus.req_ready), 0);
  endtask

  // Single uncontended transaction with fixed-latency checks.
  task automatic run_txn(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [7:0] o, input logic of_und,
                         input logic err, input logic zero);
    logic [1:0] onehot;
    onehot = (r == 1) ? 2'b10 : 2'b01;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.req_a[r*8 +: 8] = a;
    bus.req_b[r*8 +: 8] = b;
    bus.req_op[r*4 +: 4] = op;
    bus.req_valid = onehot;
    bus.rsp_ready = 2'b11;
    #1;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(onehot));
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    chk({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    if (err) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(onehot));
    chk({tag, " rsp_o"}, 32'(bus.rsp_o), 32'(o));
    chk({tag, " flags of/err/zero"}, 32'({bus.rsp_of_und, bus.rsp_err, bus.rsp_zero}),
        32'({of_und, err, zero}));
    chk({tag, " err_cnt"}, 32'(bus.err_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    chk({tag, " rsp_valid clear"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;

    //          r  a      b      op     o      of    err   zero
    vecs[0]  = '{0, 8'd200, 8'd100, 4'd0, 8'd44,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1, 8'd1,   8'd2,   4'd0, 8'd3,   1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'd5,   8'd7,   4'd1, 8'hFE,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1, 8'd7,   8'd5,   4'd1, 8'd2,   1'b0, 1'b0, 1'b0};
    vecs[4]  = '{0, 8'h81,  8'd1,   4'd2, 8'h02,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'hF0,  8'd9,   4'd3, 8'h00,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{0, 8'h00,  8'd12,  4'd2, 8'h00,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'h01,  8'd7,   4'd2, 8'h80,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{0, 8'h03,  8'd8,   4'd2, 8'h00,  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1, 8'hF0,  8'd4,   4'd3, 8'h0F,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{0, 8'd9,   8'd9,   4'd4, 8'h00,  1'b0, 1'b0, 1'b1};
    vecs[11] = '{1, 8'd9,   8'd8,   4'd4, 8'h00,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{0, 8'd3,   8'd4,   4'd5, 8'h00,  1'b0, 1'b0, 1'b1};
    vecs[13] = '{1, 8'd4,   8'd4,   4'd5, 8'h00,  1'b0, 1'b0, 1'b0};
    vecs[14] = '{0, 8'd3,   8'd4,   4'd6, 8'h00,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{1, 8'd200, 8'd4,   4'd6, 8'h00,  1'b0, 1'b0, 1'b1};
    vecs[16] = '{0, 8'd1,   8'd2,   4'd7, 8'h00,  1'b0, 1'b1, 1'b0};
    vecs[17] = '{1, 8'hFF,  8'hFF,  4'd15, 8'h00, 1'b0, 1'b1, 1'b0};

    do_reset();

    for (int i = 0; i < 18; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].o, vecs[i].of_und, vecs[i].err, vecs[i].zero);

    // Contention right after reset: req0 first, then req1, then req0 again.
    do_reset();
    bus.req_a = {8'd9, 8'd5};
    bus.req_b = {8'd9, 8'd7};
    bus.req_op = 8'h41;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1;
    chk("cont first grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    chk("cont exec req_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    chk("cont rsp0 valid", 32'(bus.rsp_valid), 32'h1);
    chk("cont rsp0 o", 32'(bus.rsp_o), 32'hFE);
    chk("cont rsp0 of_und", 32'(bus.rsp_of_und), 1);
    chk("cont resp req_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    chk("cont idle rsp_valid", 32'(bus.rsp_valid), 0);
    chk("cont second grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    chk("cont rsp1 valid", 32'(bus.rsp_valid), 32'h2);
    chk("cont rsp1 zero", 32'(bus.rsp_zero), 1);
    chk("cont rsp1 o", 32'(bus.rsp_o), 0);
    chk("cont rsp1 of_und", 32'(bus.rsp_of_und), 0);
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    #1;
    chk("cont third grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;

    // Backpressure on requester 0 while requester 1 waits; non-owner ready ignored.
    bus.req_a = {8'h81, 8'd10};
    bus.req_b = {8'd1, 8'd20};
    bus.req_op = 8'h20;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    #1;
    chk("bp accept", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp hold%0d rsp_valid", i), 32'(bus.rsp_valid), 32'h1);
      chk($sformatf("bp hold%0d rsp_o", i), 32'(bus.rsp_o), 32'd30);
      chk($sformatf("bp hold%0d flags", i),
          32'({bus.rsp_of_und, bus.rsp_err, bus.rsp_zero}), 0);
      chk($sformatf("bp hold%0d req_ready", i), 32'(bus.req_ready), 0);
      bus.rsp_ready = 2'b10;
      @(posedge clk); #1;
    end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    chk("bp release rsp_valid", 32'(bus.rsp_valid), 0);
    chk("bp waiting req1 granted", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1;
    chk("bp req1 rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("bp req1 rsp_o", 32'(bus.rsp_o), 32'h02);
    chk("bp req1 of_und", 32'(bus.rsp_of_und), 1);
    @(posedge clk); #1;

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 256; i++)
      run_txn($sformatf("err%0d", i), i % 2, 8'(i), 8'(255 - i), 4'd9, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("err_cnt saturated", 32'(bus.err_cnt), 32'd255);

    // Reset while a response is pending.
    bus.req_a = {8'd0, 8'd1};
    bus.req_b = {8'd0, 8'd1};
    bus.req_op = 8'h09;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    chk("rstmid pre rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("rstmid pre err_cnt", 32'(bus.err_cnt), 32'd255);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rstmid err_cnt", 32'(bus.err_cnt), 0);
    chk("rstmid rsp_err", 32'(bus.rsp_err), 0);
    bus.req_valid = 2'b11;
    #1;
    chk("rstmid grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
